// File: rtl/dmem_line_responder.sv
// Memory-side responder for the data cache line refill/write-back port.
// Serves one 256-bit line read or write at a time after a fixed access latency.
module dmem_line_responder #(
  parameter int LINE_W  = 256,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t            state;
  logic [7:0]        count;
  logic              req_write;
  logic [IDX_W-1:0]  req_idx;
  logic [LINE_W-1:0] req_data;
  logic [LINE_W-1:0] line_mem [DEPTH];

  // Byte offset and index bits above the array size are deliberately ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[4:0], addr_i[31:5+IDX_W]};

  // The ACK state is the last busy cycle; ack_o/data_o are registered out of it,
  // so the ack pulse lands LATENCY edges after acceptance while the FSM is
  // already back in IDLE and able to accept the next request.
  // NOTE: all state here uses non-blocking assignments so every flop samples
  // pre-edge values; blocking assignments would create order-dependent races.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= S_IDLE;
      count  <= '0;
      ack_o  <= 1'b0;
      data_o <= '0;
      busy_o <= 1'b0;
    end else begin
      ack_o  <= 1'b0;
      data_o <= '0;
      case (state)
        S_IDLE: begin
          if (enable_i) begin
            req_write <= write_i;
            req_idx   <= addr_i[5+IDX_W-1:5];
            req_data  <= data_i;
            count     <= LAT_M1;
            busy_o    <= 1'b1;
            state     <= (LATENCY == 1) ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          count <= count - 8'd1;
          if (count == 8'd1) state <= S_ACK;
        end
        S_ACK: begin
          ack_o  <= 1'b1;
          busy_o <= 1'b0;
          state  <= S_IDLE;
          if (!req_write) data_o <= line_mem[req_idx];
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the line array has no reset; it models off-chip memory contents that
  // survive a controller reset, and a reset port would also block RAM inference.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state == S_ACK && req_write) line_mem[req_idx] <= req_data;
  end

endmodule
